// File: rtl/neosd_pkg.sv
// Shared types and CRC-16/CCITT constants for the multi-lane SD DAT CRC engine.
package neosd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_TX = 1'b0,
    MODE_RX = 1'b1
  } mode_t;

  localparam int CRC_LEN     = 16;
  localparam int CRC_TAP_HI  = 15;
  localparam int CRC_TAP_MID = 10;
  localparam int CRC_TAP_LO  = 3;

  // Register is bit-reversed: r[0] holds the CRC MSB, so it shifts out first.
  function automatic logic [CRC_LEN-1:0] crc_shift(input logic [CRC_LEN-1:0] r,
                                                   input logic fb);
    logic [CRC_LEN-1:0] n;
    n              = r >> 1;
    n[CRC_TAP_HI]  = fb;
    n[CRC_TAP_MID] = r[CRC_TAP_MID+1] ^ fb;
    n[CRC_TAP_LO]  = r[CRC_TAP_LO+1] ^ fb;
    return n;
  endfunction

endpackage

// File: rtl/neosd_dat_crc_lane.sv
// One DAT lane CRC-16 register: clear, shift-in of data, shift-out with masked feedback.
module neosd_dat_crc_lane
  import neosd_pkg::*;
(
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr,
  input  logic shift_in,
  input  logic shift_out,
  input  logic din,
  output logic crc_next,
  output logic mismatch
);

  logic [CRC_LEN-1:0] crc_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (shift_in) begin
      crc_q <= crc_shift(crc_q, din ^ crc_q[0]);
    end else if (shift_out) begin
      crc_q <= crc_shift(crc_q, 1'b0);
    end
  end

  // After any shift the new r[0] is the current r[1]; lets the top register data_o.
  assign crc_next = crc_q[1];
  assign mismatch = din ^ crc_q[0];

endmodule

// File: rtl/neosd_dat_crc_multi.sv
// Multi-lane SD DAT CRC-16 engine: TX generates, RX checks, one block per start.
// Optional abort input enabled by defining NEOSD_DAT_CRC_ABORT_EN.
module neosd_dat_crc_multi
  import neosd_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LEN_W = 13
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clkstrb_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [LANES-1:0] data_i,
`ifdef NEOSD_DAT_CRC_ABORT_EN
  input  logic             abort_i,
`endif
  output logic [LANES-1:0] data_o,
  output logic             crc_oe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LANES-1:0] crc_err_o
);

  state_t           state_q;
  mode_t            mode_q;
  logic [LEN_W-1:0] cnt_q;
  logic [3:0]       crc_cnt_q;
  logic [LANES-1:0] err_q, data_q, crc_next, mismatch;
  logic             oe_q, busy_q, done_q;
  logic             abort, start_ok, lane_clr, data_stb, crc_stb;

`ifdef NEOSD_DAT_CRC_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // A start coinciding with the done pulse is dropped on purpose.
  assign start_ok = (state_q == ST_IDLE) && start_i && !done_q && !abort;
  assign lane_clr = start_ok || abort;
  assign data_stb = (state_q == ST_DATA) && clkstrb_i;
  assign crc_stb  = (state_q == ST_CRC) && clkstrb_i;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    neosd_dat_crc_lane u_lane (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .clr      (lane_clr),
      .shift_in (data_stb),
      .shift_out(crc_stb),
      .din      (data_i[l]),
      .crc_next (crc_next[l]),
      .mismatch (mismatch[l])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_TX;
      cnt_q     <= '0;
      crc_cnt_q <= '0;
      err_q     <= '0;
      data_q    <= '1;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        crc_cnt_q <= '0;
        err_q     <= '0;
        data_q    <= '1;
        oe_q      <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_ok) begin
              mode_q    <= mode_t'(mode_i);
              cnt_q     <= len_i;
              crc_cnt_q <= '0;
              err_q     <= '0;
              busy_q    <= 1'b1;
              if (len_i == '0) begin
                state_q <= ST_CRC;
                if (mode_t'(mode_i) == MODE_TX) begin
                  data_q <= '0;
                  oe_q   <= 1'b1;
                end
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (clkstrb_i) begin
              if (cnt_q == LEN_W'(1)) begin
                state_q <= ST_CRC;
                cnt_q   <= '0;
                if (mode_q == MODE_TX) begin
                  data_q <= crc_next;
                  oe_q   <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q - LEN_W'(1);
              end
            end
          end
          ST_CRC: begin
            if (clkstrb_i) begin
              if (mode_q == MODE_RX) err_q <= err_q | mismatch;
              if (crc_cnt_q == 4'(CRC_LEN - 1)) begin
                state_q   <= ST_IDLE;
                crc_cnt_q <= '0;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                data_q    <= '1;
                oe_q      <= 1'b0;
              end else begin
                crc_cnt_q <= crc_cnt_q + 4'd1;
                if (mode_q == MODE_TX) data_q <= crc_next;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_o    = data_q;
  assign crc_oe_o  = oe_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign crc_err_o = err_q;

endmodule

// File: tb/tb_neosd_dat_crc_multi.sv
// Self-checking bench for neosd_dat_crc_multi using a scoreboard of expected CRC bits and error flags.
module tb_neosd_dat_crc_multi;

  localparam int LANES = 4;
  localparam int LEN_W = 13;

  logic             clk_i, rstn_i, clkstrb_i, start_i, mode_i;
  logic [LEN_W-1:0] len_i;
  logic [LANES-1:0] data_i, data_o, crc_err_o;
  logic             crc_oe_o, busy_o, done_o;
`ifdef NEOSD_DAT_CRC_ABORT_EN
  logic             abort_i;
`endif

  int total = 0;
  int bad   = 0;

  logic [LANES-1:0] exp_q[$];
  logic [LANES-1:0] err_q[$];

  neosd_dat_crc_multi #(.LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clkstrb_i(clkstrb_i),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .len_i    (len_i),
    .data_i   (data_i),
`ifdef NEOSD_DAT_CRC_ABORT_EN
    .abort_i  (abort_i),
`endif
    .data_o   (data_o),
    .crc_oe_o (crc_oe_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .crc_err_o(crc_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic data_bit(input int pat, input int lane, input int k);
    if (pat == 0) return 1'b1;
    return ((k * (lane + 3) + (k >> 3)) % 5) < 2;
  endfunction

  // Textbook MSB-first CRC-16/CCITT, zero initial value.
  function automatic logic [15:0] model_crc(input int pat, input int lane, input int len);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int k = 0; k < len; k++) begin
      fb = data_bit(pat, lane, k) ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // ev: 0 none, 1 stray starts (mid-DATA and in done cycle), 2 reset in CRC phase, 3 abort
  task automatic applyStimulus(input string tag, input logic mode, input int len, input int pat,
                               input logic use_const, input logic [15:0] const_crc,
                               input int flip_lane, input int div, input int ev, input int ev_at);
    logic [15:0]      crc [LANES];
    logic [LANES-1:0] v, expv, fm;
    int               k, cyc, limit, cb;
    logic             strobe, finished, aborted;

    fm = '0;
    for (int l = 0; l < LANES; l++) begin
      crc[l] = use_const ? const_crc : model_crc(pat, l, len);
      if (l == flip_lane) fm[l] = 1'b1;
    end
    if (mode == 1'b0) begin
      for (int b = 0; b < 16; b++) begin
        for (int l = 0; l < LANES; l++) v[l] = crc[l][15-b];
        exp_q.push_back(v);
      end
    end else begin
      err_q.push_back(fm);
    end

    start_i   = 1'b1;
    mode_i    = mode;
    len_i     = len[LEN_W-1:0];
    clkstrb_i = 1'b1;
    data_i    = '0;
    step();
    start_i = 1'b0;
    checkOutput({tag, "/busy_rise"}, {15'd0, busy_o}, 16'd1);

    k = 0; cyc = 0; finished = 1'b0; aborted = 1'b0;
    limit = (len + 16) * ((div == 0) ? 10 : div) + 100;
    while (!finished && cyc < limit) begin
      start_i = 1'b0;
      strobe  = (div == 0) ? ($urandom_range(0, 2) == 0) : ((cyc % div) == div - 1);
      cyc++;
      clkstrb_i = strobe;
      if (strobe) begin
        if (k < len) begin
          for (int l = 0; l < LANES; l++) data_i[l] = data_bit(pat, l, k);
          if (ev == 1 && k == ev_at) begin
            start_i = 1'b1;
            mode_i  = ~mode;
            len_i   = 13'd5;
          end
`ifdef NEOSD_DAT_CRC_ABORT_EN
          if (ev == 3 && k == ev_at) begin
            abort_i = 1'b1;
            aborted = 1'b1;
          end
`endif
        end else begin
          cb = k - len;
          for (int l = 0; l < LANES; l++)
            data_i[l] = (mode == 1'b1) ? (crc[l][15-cb] ^ (fm[l] && cb == 7))
                                       : 1'($urandom_range(0, 1));
          if (mode == 1'b0) begin
            expv = exp_q.pop_front();
            checkOutput({tag, "/crc_bit"}, {12'd0, data_o}, {12'd0, expv});
            checkOutput({tag, "/crc_oe"}, {15'd0, crc_oe_o}, 16'd1);
          end else if (cb == 0) begin
            checkOutput({tag, "/rx_idle_out"}, {11'd0, crc_oe_o, data_o}, {11'd0, 1'b0, {LANES{1'b1}}});
          end
          if (cb == 15) checkOutput({tag, "/pre_done"}, {14'd0, done_o, busy_o}, 16'd1);
          if (ev == 2 && cb == ev_at) begin
            rstn_i    = 1'b0;
            clkstrb_i = 1'b0;
            #2;
            checkOutput({tag, "/reset_outs"},
                        {5'd0, data_o, crc_oe_o, busy_o, done_o, crc_err_o},
                        {5'd0, {LANES{1'b1}}, 3'b000, {LANES{1'b0}}});
            @(posedge clk_i);
            #1;
            rstn_i = 1'b1;
            exp_q.delete();
            err_q.delete();
            return;
          end
        end
      end
      step();
`ifdef NEOSD_DAT_CRC_ABORT_EN
      if (aborted) begin
        abort_i   = 1'b0;
        clkstrb_i = 1'b0;
        checkOutput({tag, "/abort_outs"},
                    {6'd0, data_o, crc_oe_o, busy_o, crc_err_o},
                    {6'd0, {LANES{1'b1}}, 2'b00, {LANES{1'b0}}});
        step();
        checkOutput({tag, "/abort_no_done"}, {15'd0, done_o}, 16'd0);
        exp_q.delete();
        err_q.delete();
        return;
      end
`endif
      if (strobe) k++;
      if (k == len + 16) finished = 1'b1;
    end

    clkstrb_i = 1'b0;
    checkOutput({tag, "/finished"}, {15'd0, finished}, 16'd1);
    checkOutput({tag, "/done"}, {13'd0, done_o, busy_o, crc_oe_o}, 16'b100);
    checkOutput({tag, "/idle_data"}, {12'd0, data_o}, {12'd0, {LANES{1'b1}}});
    if (mode == 1'b1) begin
      expv = err_q.pop_front();
      checkOutput({tag, "/crc_err"}, {12'd0, crc_err_o}, {12'd0, expv});
    end else begin
      expv = '0;
      checkOutput({tag, "/crc_err_tx"}, {12'd0, crc_err_o}, 16'd0);
    end
    if (ev == 1) start_i = 1'b1;
    step();
    start_i = 1'b0;
    checkOutput({tag, "/after_done"}, {14'd0, done_o, busy_o}, 16'd0);
    checkOutput({tag, "/err_sticky"}, {12'd0, crc_err_o}, {12'd0, expv});
  endtask

  initial begin
    rstn_i    = 1'b0;
    clkstrb_i = 1'b0;
    start_i   = 1'b0;
    mode_i    = 1'b0;
    len_i     = '0;
    data_i    = '0;
`ifdef NEOSD_DAT_CRC_ABORT_EN
    abort_i   = 1'b0;
`endif
    #12;
    checkOutput("reset_state", {5'd0, data_o, crc_oe_o, busy_o, done_o, crc_err_o},
                {5'd0, {LANES{1'b1}}, 3'b000, {LANES{1'b0}}});
    rstn_i = 1'b1;
    step();

    applyStimulus("tx4096",     1'b0, 4096, 0, 1'b1, 16'h7FA1, -1, 4, 0, 0);
    applyStimulus("rx_ok",      1'b1, 1024, 0, 1'b0, 16'h0000, -1, 2, 0, 0);
    applyStimulus("rx_flip2",   1'b1, 1024, 0, 1'b0, 16'h0000,  2, 3, 0, 0);
    applyStimulus("tx_len0",    1'b0,    0, 0, 1'b1, 16'h0000, -1, 2, 0, 0);
    applyStimulus("tx_stray",   1'b0,  300, 1, 1'b0, 16'h0000, -1, 1, 1, 150);
    applyStimulus("rx_jitter",  1'b1,  200, 1, 1'b0, 16'h0000,  0, 0, 0, 0);
    applyStimulus("tx_rst",     1'b0,  200, 1, 1'b0, 16'h0000, -1, 2, 2, 5);
    applyStimulus("tx_postrst", 1'b0, 4096, 0, 1'b1, 16'h7FA1, -1, 2, 0, 0);
    applyStimulus("tx_maxlen",  1'b0, 8191, 1, 1'b0, 16'h0000, -1, 1, 0, 0);
`ifdef NEOSD_DAT_CRC_ABORT_EN
    applyStimulus("tx_abort",   1'b0,  300, 1, 1'b0, 16'h0000, -1, 2, 3, 100);
    applyStimulus("tx_postabt", 1'b0,   64, 1, 1'b0, 16'h0000, -1, 1, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
